// File: rtl/mul_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
//   mul_state_e          : controller states
//   MUL_FIX_VAL_DEFAULT  : raw product that the fixup step bumps by one
package mul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        FIX,
        DONE
    } mul_state_e;

    localparam int unsigned MUL_FIX_VAL_DEFAULT = 10;

endpackage

// File: rtl/shift_add_mul_unit.sv
// Iterative shift-and-add multiplier, one product per valid/ready transaction.
// Timing: accept edge, one setup edge, WIDTH iteration edges, one fixup edge;
// out_valid is visible after the (WIDTH+2)th edge following the accept edge.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   in_valid/in_ready/in_a/in_b operand handshake (a = multiplicand, b = multiplier)
//   out_valid/out_ready         result handshake, result held until accepted
//   out_result                  product mod 2^WIDTH, after optional fixup
//   busy                        high in SETUP, RUN and FIX
//   done_cnt                    number of results accepted, wraps at 2^32
module shift_add_mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FIX_EN  = 1,
    parameter int unsigned FIX_VAL = MUL_FIX_VAL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy,
    output logic [31:0]      done_cnt
);

    localparam int unsigned    IterW    = $clog2(WIDTH + 1);
    localparam logic [IterW-1:0] LastIter = IterW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] FixVal   = WIDTH'(FIX_VAL);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IterW-1:0] iter_q, iter_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      done_cnt_q, done_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            iter_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            iter_q      <= iter_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        iter_d      = iter_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        done_cnt_d  = done_cnt_q;
        in_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    iter_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = RUN;
            end
            RUN: begin
                // Always WIDTH iterations, even once b is exhausted, to keep fixed latency.
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                iter_d = iter_q + IterW'(1);
                if (iter_q == LastIter) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if ((FIX_EN != 0) && (acc_q == FixVal)) begin
                    result_d = acc_q + WIDTH'(1);
                end else begin
                    result_d = acc_q;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 32'd1;
                    // Retire and accept on the same edge so back-to-back pairs see no bubble.
                    if (in_valid) begin
                        a_d     = in_a;
                        b_d     = in_b;
                        acc_d   = '0;
                        iter_d  = '0;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign done_cnt   = done_cnt_q;
    assign busy       = (state_q == SETUP) || (state_q == RUN) || (state_q == FIX);

endmodule

// File: tb/tb_shift_add_mul_unit.sv
// Self-checking bench for shift_add_mul_unit. A second instance with the fixup
// disabled shares all inputs; both are compared against a plain-arithmetic model.
module tb_shift_add_mul_unit;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_a, in_b;
    logic          out_ready;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  out_result;
    logic [31:0]   done_cnt;
    logic          in_ready2, out_valid2, busy2;
    logic [W-1:0]  out_result2;
    logic [31:0]   done_cnt2;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    shift_add_mul_unit #(.WIDTH(W), .FIX_EN(1), .FIX_VAL(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .busy(busy), .done_cnt(done_cnt)
    );

    shift_add_mul_unit #(.WIDTH(W), .FIX_EN(0), .FIX_VAL(10)) dut_nofix (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .busy(busy2), .done_cnt(done_cnt2)
    );

    // Reference: true product truncated to W bits, then the fixup rule.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit fix_en);
        longint unsigned p;
        logic [W-1:0]    r;
        p = longint'(a) * longint'(b);
        r = p[W-1:0];
        if (fix_en && r == 10) r = r + 1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called right after the accept edge; returns edges until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int lat;
        bit ok;
        logic [W-1:0] held;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;   // must not disturb the in-flight operation
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_out(lat);
        check("latency", lat, LAT);
        check("result", out_result, model(a, b, 1'b1));
        check("result_nofix", out_result2, model(a, b, 1'b0));
        held = out_result;
        ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_result === held && in_ready === 1'b0 && busy === 1'b0))
                ok = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) check("hold_stable", {31'd0, ok}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_cnt++;
        check("out_valid_dropped", {31'd0, out_valid}, 32'd0);
        check("done_cnt", done_cnt, exp_cnt);
    endtask

    logic [W-1:0] qa[3];
    logic [W-1:0] qb[3];
    int lat;
    int spurious;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_cnt", done_cnt, 32'd0);
        rst = 1'b0;

        // Directed products, fixup and wrap cases.
        run_txn(32'd3, 32'd4, 0);
        run_txn(32'd2, 32'd5, 0);
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_txn(32'hFFFF_FFFF, 32'd2, 0);
        run_txn(32'd5, 32'd0, 0);
        // Backpressure for 10 cycles.
        run_txn(32'd1234, 32'd5678, 10);

        // Back-to-back with in_valid held and out_ready high.
        qa[0] = 32'd6; qb[0] = 32'd7;
        qa[1] = 32'd0; qb[1] = 32'd9;
        qa[2] = 32'd1; qb[2] = 32'd1;
        @(negedge clk);
        in_a = qa[0]; in_b = qb[0]; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            wait_out(lat);
            check("b2b_latency", lat, LAT);
            check("b2b_result", out_result, model(qa[i], qb[i], 1'b1));
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            if (i < 2) begin
                in_a = qa[i+1]; in_b = qb[i+1];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            exp_cnt++;
        end
        #1;
        out_ready = 1'b0;
        check("b2b_done_cnt", done_cnt, exp_cnt);
        check("b2b_idle", {31'd0, out_valid}, 32'd0);

        // Random operands (some small, to hit the fixup value) with random backpressure.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            ra = (i % 2 == 0) ? W'($urandom_range(0, 12)) : W'($urandom);
            rb = (i % 2 == 0) ? W'($urandom_range(0, 12)) : W'($urandom);
            run_txn(ra, rb, $urandom_range(0, 3));
        end

        // Reset in the middle of RUN, around iteration 15.
        @(negedge clk);
        in_a = 32'd123; in_b = 32'd456; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done_cnt", done_cnt, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious++;
        end
        check("midrst_no_out_valid", spurious, 32'd0);
        run_txn(32'd4, 32'd4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
